// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with two write ports, optional zero register,
// write-to-read bypass, optional registered reads and a per-register pending scoreboard.
module regfile_mp #(
    parameter int DW       = 16,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    parameter int REG_RD   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we0,
    input  logic [AW-1:0]       waddr0,
    input  logic [DW-1:0]       wdata0,
    input  logic                we1,
    input  logic [AW-1:0]       waddr1,
    input  logic [DW-1:0]       wdata1,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*DW-1:0]   rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [DEPTH-1:0]    pending
);

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] pend;

    // Port 1 is checked first so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!(ZERO_REG != 0 && i == 0)) begin
                    if (we1 && waddr1 == AW'(i)) begin
                        mem[i] <= wdata1;
                    end else if (we0 && waddr0 == AW'(i)) begin
                        mem[i] <= wdata0;
                    end
                end
            end
        end
    end

    // A reserve outranks a write to the same register: the new producer is still outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ZERO_REG != 0 && i == 0) begin
                    pend[i] <= 1'b0;
                end else if (rsv_en && rsv_addr == AW'(i)) begin
                    pend[i] <= 1'b1;
                end else if ((we0 && waddr0 == AW'(i)) || (we1 && waddr1 == AW'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    assign pending = pend;

    genvar k;
    generate
        for (k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0] addr;
            logic [DW-1:0] val;
            logic          busy;
            logic          rsv_hit;

            assign addr    = raddr[k*AW +: AW];
            assign rsv_hit = rsv_en && (rsv_addr == addr);

            always_comb begin
                val  = mem[addr];
                busy = pend[addr];
                if (BYPASS != 0) begin
                    if (we0 && waddr0 == addr) begin
                        val  = wdata0;
                        busy = pend[addr] && rsv_hit;
                    end
                    if (we1 && waddr1 == addr) begin
                        val  = wdata1;
                        busy = pend[addr] && rsv_hit;
                    end
                end
                if (ZERO_REG != 0 && addr == '0) begin
                    val  = '0;
                    busy = 1'b0;
                end
            end

            if (REG_RD != 0) begin : g_reg
                logic [DW-1:0] val_q;
                logic          busy_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        val_q  <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        val_q  <= val;
                        busy_q <= busy;
                    end
                end

                assign rdata[k*DW +: DW] = val_q;
                assign rbusy[k]          = busy_q;
            end else begin : g_comb
                assign rdata[k*DW +: DW] = val;
                assign rbusy[k]          = busy;
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: four instances (default, no bypass, registered read,
// zero register) share one stimulus stream and are checked against hand-computed values.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        we0;
    logic [3:0]  waddr0;
    logic [15:0] wdata0;
    logic        we1;
    logic [3:0]  waddr1;
    logic [15:0] wdata1;
    logic [7:0]  raddr;
    logic        rsv_en;
    logic [3:0]  rsv_addr;

    logic [31:0] rdata_d, rdata_nb, rdata_rr, rdata_z;
    logic [1:0]  rbusy_d, rbusy_nb, rbusy_rr, rbusy_z;
    logic [15:0] pending_d, pending_nb, pending_rr, pending_z;

    int tests;
    int failures;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_d), .rbusy(rbusy_d),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending(pending_d)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending(pending_nb)
    );

    regfile_mp #(.REG_RD(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_rr), .rbusy(rbusy_rr),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending(pending_rr)
    );

    regfile_mp #(.ZERO_REG(1)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_z), .rbusy(rbusy_z),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending(pending_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic        s_we0,
        input logic [3:0]  s_waddr0,
        input logic [15:0] s_wdata0,
        input logic        s_we1,
        input logic [3:0]  s_waddr1,
        input logic [15:0] s_wdata1,
        input logic        s_rsv_en,
        input logic [3:0]  s_rsv_addr,
        input logic [7:0]  s_raddr
    );
        we0      = s_we0;
        waddr0   = s_waddr0;
        wdata0   = s_wdata0;
        we1      = s_we1;
        waddr1   = s_waddr1;
        wdata1   = s_wdata1;
        rsv_en   = s_rsv_en;
        rsv_addr = s_rsv_addr;
        raddr    = s_raddr;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0, {4'd0, 4'd0});
        tick();
        tick();

        checkOutput("reset_pending", 64'(pending_d), 64'h0);
        checkOutput("reset_rdata", 64'(rdata_d), 64'h0);
        checkOutput("reset_rdata_rr", 64'(rdata_rr), 64'h0);
        checkOutput("reset_rbusy", 64'(rbusy_d), 64'h0);

        // Basic write then read.
        rst_n = 1'b1;
        applyStimulus(1, 4'd3, 16'hA5A5, 0, 4'd0, 16'h0, 0, 4'd0, {4'd0, 4'd0});
        tick();
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0, {4'd4, 4'd3});
        #1;
        checkOutput("wr_rd", 64'(rdata_d), 64'h0000_A5A5);
        checkOutput("wr_rd_nb", 64'(rdata_nb), 64'h0000_A5A5);
        tick();
        checkOutput("wr_rd_rr", 64'(rdata_rr), 64'h0000_A5A5);

        // Same-address collision, then two distinct writes.
        applyStimulus(1, 4'd7, 16'h1111, 1, 4'd7, 16'h2222, 0, 4'd0, {4'd4, 4'd3});
        tick();
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0, {4'd7, 4'd7});
        #1;
        checkOutput("collision", 64'(rdata_d), 64'h2222_2222);
        checkOutput("collision_nb", 64'(rdata_nb), 64'h2222_2222);
        applyStimulus(1, 4'd5, 16'h5555, 1, 4'd6, 16'h6666, 0, 4'd0, {4'd7, 4'd7});
        tick();
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0, {4'd6, 4'd5});
        #1;
        checkOutput("dual_write", 64'(rdata_d), 64'h6666_5555);
        tick();
        checkOutput("dual_write_rr", 64'(rdata_rr), 64'h6666_5555);

        // Same-cycle bypass on port 1 write.
        applyStimulus(0, 4'd0, 16'h0, 1, 4'd9, 16'hBEEF, 0, 4'd0, {4'd0, 4'd9});
        #1;
        checkOutput("bypass", 64'(rdata_d), 64'h0000_BEEF);
        checkOutput("no_bypass", 64'(rdata_nb), 64'h0000_0000);
        checkOutput("bypass_rr_before", 64'(rdata_rr), 64'h6666_5555);
        tick();
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0, {4'd0, 4'd9});
        #1;
        checkOutput("bypass_rr_after", 64'(rdata_rr), 64'h0000_BEEF);
        checkOutput("no_bypass_after", 64'(rdata_nb), 64'h0000_BEEF);

        // Scoreboard reserve, clear by write, reserve beats write.
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 4'd2, {4'd2, 4'd3});
        tick();
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0, {4'd2, 4'd3});
        #1;
        checkOutput("rsv_pending", 64'(pending_d), 64'h0004);
        checkOutput("rsv_rbusy", 64'(rbusy_d), 64'h2);
        checkOutput("rsv_rbusy_rr_early", 64'(rbusy_rr), 64'h0);
        tick();
        checkOutput("rsv_rbusy_rr", 64'(rbusy_rr), 64'h2);
        applyStimulus(1, 4'd2, 16'h2222, 0, 4'd0, 16'h0, 0, 4'd0, {4'd2, 4'd3});
        #1;
        checkOutput("rbusy_bypass_clear", 64'(rbusy_d), 64'h0);
        checkOutput("rbusy_no_bypass", 64'(rbusy_nb), 64'h2);
        tick();
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0, {4'd2, 4'd3});
        #1;
        checkOutput("write_clears", 64'(pending_d), 64'h0000);
        applyStimulus(1, 4'd2, 16'h3333, 0, 4'd0, 16'h0, 1, 4'd2, {4'd2, 4'd3});
        tick();
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0, {4'd2, 4'd3});
        #1;
        checkOutput("rsv_beats_write", 64'(pending_d), 64'h0004);
        checkOutput("rsv_write_data", 64'(rdata_d), 64'h3333_A5A5);

        // Zero register ignores writes and reserves.
        applyStimulus(1, 4'd0, 16'hFFFF, 0, 4'd0, 16'h0, 1, 4'd0, {4'd0, 4'd0});
        #1;
        checkOutput("zero_bypass", 64'(rdata_z), 64'h0);
        checkOutput("nonzero_bypass", 64'(rdata_d), 64'hFFFF_FFFF);
        tick();
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0, {4'd0, 4'd0});
        #1;
        checkOutput("zero_read", 64'(rdata_z), 64'h0);
        checkOutput("zero_pending", 64'(pending_z), 64'h0004);
        checkOutput("nonzero_pending", 64'(pending_d), 64'h0005);
        checkOutput("nonzero_rbusy", 64'(rbusy_d), 64'h3);

        // Reserve everything, then reset mid-cycle with a write in flight.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 4'(i), {4'd3, 4'd3});
            tick();
        end
        applyStimulus(1, 4'd10, 16'hABCD, 0, 4'd0, 16'h0, 0, 4'd0, {4'd3, 4'd3});
        checkOutput("all_pending", 64'(pending_d), 64'hFFFF);
        checkOutput("all_pending_zero", 64'(pending_z), 64'hFFFE);
        checkOutput("pre_reset_rdata", 64'(rdata_d), 64'hA5A5_A5A5);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_pending", 64'(pending_d), 64'h0);
        checkOutput("async_rdata", 64'(rdata_d), 64'h0);
        checkOutput("async_rbusy", 64'(rbusy_d), 64'h0);
        checkOutput("async_rdata_rr", 64'(rdata_rr), 64'h0);
        checkOutput("async_pending_zero", 64'(pending_z), 64'h0);
        tick();
        rst_n = 1'b1;
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0, {4'd10, 4'd10});
        #1;
        checkOutput("reset_discards_write", 64'(rdata_d), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
